// File: rtl/output_buffer_pkg.sv
// Shared accelerator constants and types for the activation output buffer.
package output_buffer_pkg;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 8;
  localparam int OCC_W  = $clog2(DEPTH) + 1;

  typedef logic [DATA_W-1:0] row_t;
  typedef logic [OCC_W-1:0]  occ_t;

endpackage

// File: rtl/output_fifo_mem.sv
// DEPTH x DATA_W register file: one synchronous write port, one asynchronous read port.
module output_fifo_mem #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 64,
  parameter int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: storage is deliberately not reset; the controller masks rdata while
  // empty, so stale contents are never visible and the array stays plain flops.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/output_buffer.sv
// Activation output FIFO read by the AHB subordinate; tracks occupancy, sticky
// overflow/underflow errors and a per-inference "all rows produced" indication.
module output_buffer #(
  parameter int DEPTH  = output_buffer_pkg::DEPTH,
  parameter int DATA_W = output_buffer_pkg::DATA_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          activations,
  input  logic                       activations_valid,
  input  logic                       pop,
  input  logic                       flush,
  input  logic                       clear_err,
  input  logic [$clog2(DEPTH):0]     expected_count,
  output logic [DATA_W-1:0]          rdata,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow_err,
  output logic                       underflow_err,
  output logic                       done
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  push_cnt;
  logic [CNT_W-1:0]  occ_next;
  logic [DATA_W-1:0] mem_rdata;
  logic              do_pop, do_push, ovf_evt, unf_evt;

  // NOTE: every always_comb output gets a default first so no path can
  // leave a value held, which would otherwise infer a latch.
  always_comb begin
    do_pop   = pop && !empty;
    // A pop frees the slot this cycle, so a full buffer still accepts the push.
    do_push  = activations_valid && (!full || do_pop);
    ovf_evt  = activations_valid && full && !do_pop;
    unf_evt  = pop && empty;
    occ_next = occupancy;
    case ({do_push, do_pop})
      2'b10:   occ_next = occupancy + CNT_W'(1);
      2'b01:   occ_next = occupancy - CNT_W'(1);
      default: occ_next = occupancy;
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values, and rst clears it without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      occupancy     <= '0;
      push_cnt      <= '0;
      full          <= 1'b0;
      empty         <= 1'b1;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else if (flush) begin
      // Flush outranks everything else, including error set and clear.
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      push_cnt  <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
        if (push_cnt != CNT_W'(DEPTH)) push_cnt <= push_cnt + CNT_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      occupancy     <= occ_next;
      full          <= (occ_next == CNT_W'(DEPTH));
      empty         <= (occ_next == '0);
      // A new error event in the same cycle as clear_err keeps the flag set.
      overflow_err  <= (overflow_err  && !clear_err) || ovf_evt;
      underflow_err <= (underflow_err && !clear_err) || unf_evt;
    end
  end

  output_fifo_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (do_push && !flush),
    .waddr (wr_ptr),
    .wdata (activations),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  assign rdata = empty ? '0 : mem_rdata;
  assign done  = (expected_count != '0) && (push_cnt >= expected_count);

endmodule

// File: tb/tb_output_buffer.sv
// Directed scoreboard bench for output_buffer: push/pop ordering, wrap, errors,
// done/flush behaviour and asynchronous reset.
module tb_output_buffer;
  import output_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  row_t activations = '0;
  logic activations_valid = 1'b0;
  logic pop = 1'b0;
  logic flush = 1'b0;
  logic clear_err = 1'b0;
  occ_t expected_count = occ_t'(DEPTH);

  row_t rdata;
  occ_t occupancy;
  logic full, empty, overflow_err, underflow_err, done;

  int   total = 0;
  int   bad   = 0;
  row_t sb[$];
  row_t rows[8] = '{64'haaaa_aaaa_aaaa_aaaa, 64'hbbbb_bbbb_bbbb_bbbb,
                    64'hcccc_cccc_cccc_cccc, 64'hdddd_dddd_dddd_dddd,
                    64'heeee_eeee_eeee_eeee, 64'hffff_ffff_ffff_ffff,
                    64'h8888_8888_8888_8888, 64'h9999_9999_9999_9999};

  output_buffer dut (
    .clk               (clk),
    .rst               (rst),
    .activations       (activations),
    .activations_valid (activations_valid),
    .pop               (pop),
    .flush             (flush),
    .clear_err         (clear_err),
    .expected_count    (expected_count),
    .rdata             (rdata),
    .occupancy         (occupancy),
    .full              (full),
    .empty             (empty),
    .overflow_err      (overflow_err),
    .underflow_err     (underflow_err),
    .done              (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare occupancy, flags and head against the scoreboard contents.
  task automatic check_state(input string tag);
    row_t head;
    head = (sb.size() == 0) ? '0 : sb[0];
    check({tag, ".occ"},   64'(occupancy), 64'(sb.size()));
    check({tag, ".full"},  64'(full),      64'(sb.size() == DEPTH));
    check({tag, ".empty"}, 64'(empty),     64'(sb.size() == 0));
    check({tag, ".rdata"}, rdata,          head);
  endtask

  task automatic push_row(input row_t v);
    activations       = v;
    activations_valid = 1'b1;
    if (sb.size() < DEPTH) sb.push_back(v);
    tick();
    activations_valid = 1'b0;
  endtask

  task automatic pop_row(input string tag);
    row_t exp_v;
    exp_v = (sb.size() == 0) ? '0 : sb.pop_front();
    check(tag, rdata, exp_v);
    pop = 1'b1;
    tick();
    pop = 1'b0;
  endtask

  task automatic push_pop(input string tag, input row_t v);
    check(tag, rdata, sb.pop_front());
    sb.push_back(v);
    activations       = v;
    activations_valid = 1'b1;
    pop               = 1'b1;
    tick();
    activations_valid = 1'b0;
    pop               = 1'b0;
  endtask

  task automatic strobe_clear();
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check_state("reset");
    check("reset.ovf",  64'(overflow_err),  64'd0);
    check("reset.unf",  64'(underflow_err), 64'd0);
    check("reset.done", 64'(done),          64'd0);
    rst = 1'b0;
    tick();

    // Single push then pop
    push_row(64'h0000_ffff_0000_eeee);
    check_state("single.push");
    pop_row("single.pop");
    check_state("single.after");

    // Fill, overflow, drain
    for (int i = 0; i < 8; i++) push_row(rows[i]);
    check_state("fill");
    push_row(64'h1);
    check_state("fill.ovf");
    check("fill.ovf_err", 64'(overflow_err), 64'd1);
    for (int i = 0; i < 8; i++) pop_row("drain");
    check_state("drain.after");
    strobe_clear();
    check("ovf.cleared", 64'(overflow_err), 64'd0);

    // Full with simultaneous push/pop, then verify wrap ordering
    for (int i = 0; i < 8; i++) push_row(rows[i] ^ 64'h0101_0101_0101_0101);
    for (int i = 0; i < 8; i++) begin
      push_pop("full.pp", 64'h5000_0000_0000_0000 | 64'(i));
      check("full.pp.occ", 64'(occupancy), 64'd8);
      check("full.pp.ovf", 64'(overflow_err), 64'd0);
    end
    for (int i = 0; i < 8; i++) pop_row("wrap");
    check_state("wrap.after");

    // Underflow and clear_err interaction
    pop_row("unf.pop");
    check("unf.set", 64'(underflow_err), 64'd1);
    check_state("unf.state");
    strobe_clear();
    check("unf.clear", 64'(underflow_err), 64'd0);
    pop_row("unf.pop2");
    clear_err = 1'b1;
    pop_row("unf.pop_clr");
    clear_err = 1'b0;
    check("unf.clr_race", 64'(underflow_err), 64'd1);
    // Empty pop with push: push still completes
    activations       = 64'h7777_0000_0000_0001;
    activations_valid = 1'b1;
    pop               = 1'b1;
    sb.push_back(activations);
    tick();
    activations_valid = 1'b0;
    pop               = 1'b0;
    check_state("unf.push");
    check("unf.push.err", 64'(underflow_err), 64'd1);

    // done / flush (underflow_err stays set across flush)
    expected_count = 3;
    flush = 1'b1;
    activations_valid = 1'b1;
    tick();
    flush = 1'b0;
    activations_valid = 1'b0;
    sb.delete();
    check_state("flush1");
    check("flush1.done", 64'(done), 64'd0);
    check("flush1.unf",  64'(underflow_err), 64'd1);
    for (int i = 0; i < 3; i++) begin
      check("done.before", 64'(done), 64'd0);
      push_row(rows[i]);
    end
    check("done.rise", 64'(done), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    sb.delete();
    check_state("flush2");
    check("flush2.done", 64'(done), 64'd0);
    check("flush2.unf",  64'(underflow_err), 64'd1);

    // Async reset mid-clock with 5 entries held
    for (int i = 0; i < 5; i++) push_row(rows[i]);
    check_state("pre_rst");
    check("pre_rst.done", 64'(done), 64'd1);
    #3 rst = 1'b1;
    #1;
    sb.delete();
    check_state("async_rst");
    check("async_rst.done", 64'(done),          64'd0);
    check("async_rst.unf",  64'(underflow_err), 64'd0);
    check("async_rst.ovf",  64'(overflow_err),  64'd0);
    #1 rst = 1'b0;
    tick();
    push_row(64'h1234_5678_9abc_def0);
    check_state("post_rst");
    pop_row("post_rst.pop");
    check_state("post_rst.after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/output_buffer.md
OUTPUT_BUFFER -- requirements
Module: output_buffer

Interface
- REQ-001: Parameter DEPTH, default 8, FIFO entries (power of two).
- REQ-002: Parameter DATA_W, default 64, width of one activation row.
- REQ-003: Port clk  in  1  the single clock; all state updates on its rising edge.
- REQ-004: Port rst  in  1  reset, asynchronous and active-high.
- REQ-005: Port activations  in  DATA_W  activation row from the upstream activation unit.
- REQ-006: Port activations_valid  in  1  one-cycle push strobe qualifying activations.
- REQ-007: Port pop  in  1  one-cycle strobe from the AHB subordinate on a read of the output-data register.
- REQ-008: Port flush  in  1  one-cycle strobe that discards all contents.
- REQ-009: Port clear_err  in  1  one-cycle strobe that clears the sticky error flags.
- REQ-010: Port expected_count  in  log2(DEPTH)+1  rows expected per inference, valid range 1..DEPTH.
- REQ-011: Port rdata  out  DATA_W  head entry; 0 when empty.
- REQ-012: Port occupancy  out  log2(DEPTH)+1  number of stored entries, 0..DEPTH.
- REQ-013: Port full / empty  out  1 each  occupancy==DEPTH / occupancy==0.
- REQ-014: Port overflow_err / underflow_err  out  1 each  sticky error flags.
- REQ-015: Port done  out  1  high while rows pushed since the last flush or reset is at least expected_count.

Function
- REQ-016: Circular buffer with write pointer, read pointer, and occupancy counter; pointers wrap from DEPTH-1 to 0.
- REQ-017: Push = activations_valid and not full: store activations at the write pointer and advance it at the next edge.
- REQ-018: Pop = pop and not empty: advance the read pointer at the next edge; rdata shows the new head in the following cycle (zero-wait read of the current head).
- REQ-019: Push and pop in the same cycle, not empty: both take effect and occupancy is unchanged; this is legal when full and does not set overflow_err.
- REQ-020: Push when full without a pop: data is dropped, state is unchanged, and overflow_err is set.
- REQ-021: Pop when empty: no pointer change and underflow_err is set, even if a push occurs in the same cycle; that push still completes.
- REQ-022: Flush has priority over push, pop, and clear_err; it zeroes the pointers, occupancy, and pushed-row counter; errors are preserved.
- REQ-023: clear_err zeroes both error flags; an error event in the same cycle wins and the flag stays set.
- REQ-024: The pushed-row counter saturates at DEPTH; done is combinational from the counter and expected_count.
- REQ-025: Occupancy, full, and empty are registered and consistent with the pointers every cycle.

Reset
- REQ-026: On rst assertion, asynchronously: pointers=0, occupancy=0, pushed-row counter=0, errors=0, empty=1, full=0, done=0, rdata=0.
- REQ-027: Storage array contents are not reset; rdata is masked to 0 while empty.
- REQ-028: Reset mid-burst discards all entries; the first push after deassertion lands in entry 0.

Structure
- REQ-029: The shared accelerator package holds the DATA_W and DEPTH constants, the row typedef (logic [DATA_W-1:0]), and the occupancy typedef.
- REQ-030: Storage is one sub-module, output_fifo_mem: a DEPTH x DATA_W register file with one write port and one asynchronous read port.
- REQ-031: All control (pointers, counters, flags) lives in output_buffer.

Verification
- REQ-032: Reset, push 64'h0000_ffff_0000_eeee, pop -> rdata reads that value the cycle after push; occupancy 1->0; empty=1.
- REQ-033: Push 8 rows ...aaaa..9999, then a 9th push 64'h1 -> full=1, overflow_err=1, occupancy=8; 8 pops return aaaa..9999 in order.
- REQ-034: When full, push and pop in the same cycle -> occupancy stays 8, no overflow, and pointer wrap is verified by reading 8 more in order.
- REQ-035: Pop when empty -> underflow_err=1, rdata=0; clear_err -> flag 0; clear_err with a simultaneous empty pop -> flag stays 1.
- REQ-036: expected_count=3, push 3 rows -> done rises the cycle after the third push; flush -> done=0, occupancy=0, errors unchanged.
- REQ-037: Assert rst asynchronously mid-clock with 5 entries held -> all outputs reach reset values before the next edge; the next push appears at rdata.
